sdram_frame_fetcher: RTL and testbench



---
 rtl/sdram_frame_fetcher_if.sv | 37 +++
 rtl/sdram_frame_fetcher.sv | 256 +++++++++++++++++++++++++
 tb/tb_sdram_frame_fetcher.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_frame_fetcher_if.sv
// SDRAM read-burst and FIFO write-port bundle
// for the frame fetcher.
interface sdram_frame_fetcher_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SDRAM_AW   = 24
);
  logic                  rd_req;
  logic [SDRAM_AW-1:0]   rd_addr;
  logic                  rd_gnt;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  fifo_full;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_gnt,
    input  rd_data_valid,
    input  rd_data,
    input  fifo_full,
    output write_enable,
    output write_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_gnt,
    output rd_data_valid,
    output rd_data,
    output fifo_full,
    input  write_enable,
    input  write_data
  );
endinterface

// File: rtl/sdram_frame_fetcher.sv
// Frame fetcher: bursts the framebuffer out of SDRAM
// through a skid buffer into the VGA line FIFO.
module sdram_frame_fetcher #(
  parameter int          DATA_WIDTH = 16,
  parameter int          SDRAM_AW   = 24,
  parameter int unsigned FB_BASE    = 0,
  parameter int          H_PIXELS   = 640,
  parameter int          V_LINES    = 480,
  parameter int          BURST_LEN  = 8
) (
  input  logic clk_write,
  input  logic rst_n,
  input  logic frame_start_async,
  sdram_frame_fetcher_if.master bus,
  output logic busy,
  output logic frame_done,
  output logic frame_overrun
);

  localparam int FRAME_WORDS = H_PIXELS * V_LINES;
  localparam int SKID_DEPTH  = 2 * BURST_LEN;
  localparam int PTR_W       = $clog2(SKID_DEPTH);
  localparam int CNT_W       = $clog2(SKID_DEPTH + 1);
  localparam int WORD_W      = $clog2(FRAME_WORDS + 1);

  localparam logic [CNT_W-1:0] BURST_C =
    CNT_W'(BURST_LEN);
  localparam logic [CNT_W:0] RESV_MAX =
    (CNT_W+1)'(BURST_LEN);
  localparam logic [WORD_W-1:0] FRAME_C =
    WORD_W'(FRAME_WORDS);
  localparam logic [WORD_W-1:0] LAST_C =
    WORD_W'(FRAME_WORDS - 1);
  localparam logic [WORD_W-1:0] BURST_W =
    WORD_W'(BURST_LEN);
  localparam logic [SDRAM_AW-1:0] BASE_A =
    SDRAM_AW'(FB_BASE);
  localparam logic [SDRAM_AW-1:0] BURST_A =
    SDRAM_AW'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    ABORT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_fs_pulse;

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic [PTR_W-1:0]      r_wp;
  logic [PTR_W-1:0]      r_rp;
  logic [CNT_W-1:0]      r_occ;
  logic [CNT_W-1:0]      r_out;
  logic [SDRAM_AW-1:0]   r_addr;
  logic [WORD_W-1:0]     r_words;
  logic [WORD_W-1:0]     r_wr_cnt;
  logic                  r_held;

  logic [CNT_W:0] w_reserved;
  logic           w_req;
  logic           w_grant;
  logic           w_push;
  logic           w_pop;
  logic           w_last;
  logic           w_restart;
  logic           w_flush;

  assign w_reserved = {1'b0, r_occ} + {1'b0, r_out};
  assign w_grant    = w_req & bus.rd_gnt;
  assign w_push     = bus.rd_data_valid &
                      (r_state != ABORT);
  assign w_pop      = bus.write_enable;
  assign w_last     = w_pop & (r_wr_cnt == LAST_C);

  assign bus.rd_req       = w_req;
  assign bus.rd_addr      = r_addr;
  assign bus.write_enable = (r_occ != '0) &
                            ~bus.fifo_full &
                            (r_state != ABORT);
  assign bus.write_data   = r_mem[r_rp];

  // Two-flop synchroniser plus registered rising edge of vsync.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_fs_pulse <= 1'b0;
    end else begin
      r_sync1    <= frame_start_async;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2;
      r_fs_pulse <= r_sync2 & ~r_sync3;
    end
  end

  // Request only when a full burst still fits; an ungranted request survives an abort.
  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_req = (r_words < FRAME_C) &&
                (w_reserved <= RESV_MAX);
      end
      ABORT: begin
        w_req = r_held;
      end
      default: begin
        w_req = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and status pulses.
  always_comb begin
    w_next        = r_state;
    w_restart     = 1'b0;
    w_flush       = 1'b0;
    busy          = 1'b1;
    frame_done    = 1'b0;
    frame_overrun = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (r_fs_pulse) begin
          w_restart = 1'b1;
          w_next    = FETCH;
        end
      end
      FETCH: begin
        if (r_fs_pulse) begin
          frame_overrun = 1'b1;
          w_next        = ABORT;
        end else if (w_grant &&
                     (r_words + BURST_W == FRAME_C)) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last) begin
          frame_done = 1'b1;
          if (r_fs_pulse) begin
            w_restart = 1'b1;
            w_next    = FETCH;
          end else begin
            w_next = IDLE;
          end
        end else if (r_fs_pulse) begin
          frame_overrun = 1'b1;
          w_next        = ABORT;
        end
      end
      ABORT: begin
        w_flush = 1'b1;
        if (r_fs_pulse) begin
          frame_overrun = 1'b1;
        end
        if ((r_out == '0) && !w_req) begin
          w_restart = 1'b1;
          w_next    = FETCH;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Notes an asserted request that was not granted this edge.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= 1'b0;
    end else begin
      r_held <= w_req & ~bus.rd_gnt;
    end
  end

  // Burst address and requested-word count.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= BASE_A;
      r_words <= '0;
    end else if (w_restart) begin
      r_addr  <= BASE_A;
      r_words <= '0;
    end else if (w_grant) begin
      r_addr  <= r_addr + BURST_A;
      r_words <= r_words + BURST_W;
    end
  end

  // Words granted by the controller but not yet returned.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= r_out
             + (w_grant ? BURST_C : '0)
             - CNT_W'(bus.rd_data_valid);
    end
  end

  // Words pushed into the FIFO this frame.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
    end else if (w_restart) begin
      r_wr_cnt <= '0;
    end else if (w_pop) begin
      r_wr_cnt <= r_wr_cnt + WORD_W'(1);
    end
  end

  // Circular skid buffer; flushed while aborting.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else if (w_flush) begin
      r_rp  <= r_wp;
      r_occ <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= bus.rd_data;
        r_wp        <= r_wp + PTR_W'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PTR_W'(1);
      end
      r_occ <= r_occ
             + CNT_W'(w_push)
             - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_sdram_frame_fetcher.sv
// Bench for sdram_frame_fetcher: SDRAM controller and
// FIFO sink models with a randomised word store.
module tb_sdram_frame_fetcher;

  localparam int B  = 4;
  localparam int FW = 32;

  logic clk_write = 1'b0;
  logic rst_n;
  logic fs;
  logic gnt;
  logic dv;
  logic ff;
  logic [15:0] dat;

  logic busy1, fd1, ov1;
  logic busy2, fd2, ov2;

  sdram_frame_fetcher_if #(.DATA_WIDTH(16), .SDRAM_AW(24)) bus1 ();
  sdram_frame_fetcher_if #(.DATA_WIDTH(16), .SDRAM_AW(9))  bus2 ();

  assign bus1.rd_gnt        = gnt;
  assign bus1.rd_data_valid = dv;
  assign bus1.rd_data       = dat;
  assign bus1.fifo_full     = ff;
  assign bus2.rd_gnt        = gnt;
  assign bus2.rd_data_valid = dv;
  assign bus2.rd_data       = dat;
  assign bus2.fifo_full     = ff;

  sdram_frame_fetcher #(
    .DATA_WIDTH(16), .SDRAM_AW(24), .FB_BASE(32'h100),
    .H_PIXELS(16), .V_LINES(2), .BURST_LEN(B)
  ) dut1 (
    .clk_write(clk_write), .rst_n(rst_n),
    .frame_start_async(fs), .bus(bus1),
    .busy(busy1), .frame_done(fd1), .frame_overrun(ov1)
  );

  sdram_frame_fetcher #(
    .DATA_WIDTH(16), .SDRAM_AW(9), .FB_BASE(32'h1F8),
    .H_PIXELS(16), .V_LINES(2), .BURST_LEN(B)
  ) dut2 (
    .clk_write(clk_write), .rst_n(rst_n),
    .frame_start_async(fs), .bus(bus2),
    .busy(busy2), .frame_done(fd2), .frame_overrun(ov2)
  );

  initial forever #5 clk_write = ~clk_write;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;

  logic [15:0] mem [512];
  logic [15:0] wr_q[$];
  logic [15:0] wr2_q[$];
  logic [23:0] addr_q[$];
  logic [8:0]  addr2_q[$];
  int          bq_a[$];
  int unsigned bq_r[$];

  int done_cnt, done_idx, done_bad;
  int ovr_cnt, ovr_idx, fullwe;
  int hold_viol, full_grants, max_age;
  int gnt_delay = 2;
  int lat = 3;
  bit rand_gnt = 0, rand_lat = 0;
  bit full_force = 0, rand_full = 0;

  bit          pend;
  logic [23:0] pend_addr;
  int          age, cur_delay, beats, cur_addr;

  initial forever begin
    @(posedge clk_write);
    cyc++;
  end

  // SDRAM controller model: grant after a delay, return bursts in order.
  initial begin
    gnt = 0; dv = 0; dat = '0; ff = 0;
    pend = 0; beats = 0; age = 0; cur_delay = 0; cur_addr = 0;
    forever begin
      @(negedge clk_write);
      if (!rst_n) begin
        pend = 0; beats = 0;
        bq_a.delete(); bq_r.delete();
        gnt = 0; dv = 0; dat = '0; ff = full_force;
        continue;
      end
      if (pend && (bus1.rd_req !== 1'b1 || bus1.rd_addr !== pend_addr))
        hold_viol++;
      gnt = 0;
      if (bus1.rd_req === 1'b1) begin
        if (!pend) begin
          pend = 1; pend_addr = bus1.rd_addr; age = 0;
          cur_delay = rand_gnt ? int'($urandom_range(0, 4)) : gnt_delay;
        end
        if (age >= cur_delay) begin
          gnt = 1; pend = 0;
          if (age > max_age) max_age = age;
          addr_q.push_back(bus1.rd_addr);
          addr2_q.push_back(bus2.rd_addr);
          bq_a.push_back(int'(bus1.rd_addr));
          bq_r.push_back(cyc + 1 +
            (rand_lat ? $urandom_range(1, 6) : lat));
          if (full_force) full_grants++;
        end else begin
          age++;
        end
      end
      dv = 0;
      if (beats == 0 && bq_a.size() > 0 && bq_r[0] <= cyc) begin
        cur_addr = bq_a.pop_front();
        void'(bq_r.pop_front());
        beats = B;
      end
      if (beats > 0) begin
        dv = 1; dat = mem[cur_addr & 511];
        cur_addr++; beats--;
      end
      ff = full_force || (rand_full && $urandom_range(0, 2) == 0);
    end
  end

  // FIFO sink: log what the DUTs push just before each edge.
  initial forever begin
    @(negedge clk_write);
    #2;
    if (bus1.write_enable === 1'b1) begin
      wr_q.push_back(bus1.write_data);
      if (ff) fullwe++;
    end
    if (bus2.write_enable === 1'b1) wr2_q.push_back(bus2.write_data);
    if (fd1 === 1'b1) begin
      done_cnt++; done_idx = wr_q.size();
      if (bus1.write_enable !== 1'b1) done_bad++;
    end
    if (ov1 === 1'b1) begin
      ovr_cnt++; ovr_idx = wr_q.size();
    end
  end

  task automatic clear_logs();
    wr_q.delete(); wr2_q.delete(); addr_q.delete(); addr2_q.delete();
    done_cnt = 0; done_idx = -1; done_bad = 0;
    ovr_cnt = 0; ovr_idx = -1; fullwe = 0;
    hold_viol = 0; full_grants = 0; max_age = 0;
  endtask

  task automatic start_frame();
    @(negedge clk_write);
    fs = 1;
    repeat (6) @(negedge clk_write);
    fs = 0;
  endtask

  task automatic wait_frame(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_write);
      if (wr_q.size() >= n && busy1 === 1'b0) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk_write);
  endtask

  task automatic test_reset();
    logic [31:0] got [8];
    logic [31:0] want [8];
    string nm [8];
    rst_n = 0; fs = 0;
    repeat (3) @(negedge clk_write);
    rst_n = 1;
    repeat (2) @(negedge clk_write);
    #2;
    got[0] = 32'(bus1.rd_req);       want[0] = 0;        nm[0] = "rst_rd_req";
    got[1] = 32'(bus1.rd_addr);      want[1] = 32'h100;  nm[1] = "rst_rd_addr";
    got[2] = 32'(bus1.write_enable); want[2] = 0;        nm[2] = "rst_we";
    got[3] = 32'(bus1.write_data);   want[3] = 0;        nm[3] = "rst_wd";
    got[4] = 32'(busy1);             want[4] = 0;        nm[4] = "rst_busy";
    got[5] = 32'(fd1);               want[5] = 0;        nm[5] = "rst_done";
    got[6] = 32'(ov1);               want[6] = 0;        nm[6] = "rst_overrun";
    got[7] = 32'(bus2.rd_addr);      want[7] = 32'h1F8;  nm[7] = "rst_rd_addr2";
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got[i] !== want[i]) begin
        bad++;
        $display("FAIL %s: got %h want %h", nm[i], got[i], want[i]);
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs();
    gnt_delay = 2; lat = 3;
    start_frame();
    wait_frame(FW, 500, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL basic_timeout: got %0d words want %0d", wr_q.size(), FW);
    end
    total++;
    if (addr_q.size() != 8) begin
      bad++; $display("FAIL basic_bursts: got %0d want 8", addr_q.size());
    end
    for (int i = 0; i < 8 && i < addr_q.size(); i++) begin
      total++;
      if (addr_q[i] !== 24'(32'h100 + 4 * i)) begin
        bad++; $display("FAIL basic_addr[%0d]: got %h want %h", i, addr_q[i], 32'h100 + 4 * i);
      end
    end
    total++;
    if (wr_q.size() != FW) begin
      bad++; $display("FAIL basic_count: got %0d want %0d", wr_q.size(), FW);
    end
    for (int i = 0; i < FW && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== mem[(32'h100 + i) & 511]) begin
        bad++; $display("FAIL basic_word[%0d]: got %h want %h", i, wr_q[i], mem[(32'h100 + i) & 511]);
      end
    end
    total++;
    if (done_cnt != 1 || done_idx != FW || done_bad != 0) begin
      bad++; $display("FAIL basic_done: got cnt=%0d idx=%0d lone=%0d want 1/%0d/0", done_cnt, done_idx, done_bad, FW);
    end
    total++;
    if (busy1 !== 1'b0 || ovr_cnt != 0 || fullwe != 0) begin
      bad++; $display("FAIL basic_status: got busy=%b ovr=%0d fullwe=%0d want 0/0/0", busy1, ovr_cnt, fullwe);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int pre;
    clear_logs();
    gnt_delay = 2; lat = 3;
    start_frame();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_write);
      if (wr_q.size() >= 6) begin ok = 1; break; end
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL bp_start_timeout: got %0d words want 6", wr_q.size());
    end
    full_force = 1;
    @(negedge clk_write);
    #3;
    pre = wr_q.size();
    repeat (20) @(negedge clk_write);
    #3;
    total++;
    if (wr_q.size() != pre || fullwe != 0) begin
      bad++; $display("FAIL bp_we_while_full: got %0d writes want 0", wr_q.size() - pre + fullwe);
    end
    full_force = 0;
    total++;
    if (full_grants > 2) begin
      bad++; $display("FAIL bp_grants: got %0d want <=2", full_grants);
    end
    wait_frame(FW, 600, ok);
    total++;
    if (ok !== 1'b1 || wr_q.size() != FW) begin
      bad++; $display("FAIL bp_count: got %0d want %0d", wr_q.size(), FW);
    end
    for (int i = 0; i < FW && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== mem[(32'h100 + i) & 511]) begin
        bad++; $display("FAIL bp_word[%0d]: got %h want %h", i, wr_q[i], mem[(32'h100 + i) & 511]);
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL bp_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_handshake();
    bit ok;
    clear_logs();
    gnt_delay = 10; lat = 3;
    start_frame();
    wait_frame(FW, 1000, ok);
    gnt_delay = 2;
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL hs_timeout: got %0d words want %0d", wr_q.size(), FW);
    end
    total++;
    if (hold_viol != 0) begin
      bad++; $display("FAIL hs_hold: got %0d unstable cycles want 0", hold_viol);
    end
    total++;
    if (max_age < 10) begin
      bad++; $display("FAIL hs_wait: got %0d want 10", max_age);
    end
    total++;
    if (addr_q.size() != 8) begin
      bad++; $display("FAIL hs_bursts: got %0d want 8", addr_q.size());
    end
    for (int i = 0; i < FW && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== mem[(32'h100 + i) & 511]) begin
        bad++; $display("FAIL hs_word[%0d]: got %h want %h", i, wr_q[i], mem[(32'h100 + i) & 511]);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int n;
    clear_logs();
    gnt_delay = 2; lat = 3;
    start_frame();
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_write);
      if (wr_q.size() >= 12) begin ok = 1; break; end
    end
    fs = 1;
    for (int i = 0; i < 20 && ovr_cnt == 0; i++) @(negedge clk_write);
    repeat (4) @(negedge clk_write);
    fs = 0;
    total++;
    if (ok !== 1'b1 || ovr_cnt == 0) begin
      bad++; $display("FAIL ovr_trigger: got words=%0d ovr=%0d want >=12 and 1", wr_q.size(), ovr_cnt);
    end
    wait_frame(ovr_idx + FW, 800, ok);
    total++;
    if (ok !== 1'b1 || ovr_cnt != 1) begin
      bad++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt);
    end
    total++;
    if (ovr_idx < 12 || wr_q.size() != ovr_idx + FW) begin
      bad++; $display("FAIL ovr_count: got %0d (split %0d) want split+%0d", wr_q.size(), ovr_idx, FW);
    end
    for (int i = 0; i < ovr_idx && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== mem[(32'h100 + i) & 511]) begin
        bad++; $display("FAIL ovr_pre[%0d]: got %h want %h", i, wr_q[i], mem[(32'h100 + i) & 511]);
      end
    end
    for (int i = 0; i < FW && ovr_idx >= 0 && ovr_idx + i < wr_q.size(); i++) begin
      total++;
      if (wr_q[ovr_idx + i] !== mem[(32'h100 + i) & 511]) begin
        bad++; $display("FAIL ovr_post[%0d]: got %h want %h", i, wr_q[ovr_idx + i], mem[(32'h100 + i) & 511]);
      end
    end
    n = addr_q.size();
    for (int i = 0; i < 8 && n >= 8; i++) begin
      total++;
      if (addr_q[n - 8 + i] !== 24'(32'h100 + 4 * i)) begin
        bad++; $display("FAIL ovr_addr[%0d]: got %h want %h", i, addr_q[n - 8 + i], 32'h100 + 4 * i);
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL ovr_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_logs();
    rand_gnt = 1;
    start_frame();
    wait_frame(FW, 800, ok);
    rand_gnt = 0;
    total++;
    if (ok !== 1'b1 || addr2_q.size() != 8) begin
      bad++; $display("FAIL wrap_bursts: got %0d want 8", addr2_q.size());
    end
    for (int i = 0; i < 8 && i < addr2_q.size(); i++) begin
      total++;
      if (addr2_q[i] !== 9'((32'h1F8 + 4 * i) & 511)) begin
        bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr2_q[i], (32'h1F8 + 4 * i) & 511);
      end
    end
    total++;
    if (wr2_q.size() != FW) begin
      bad++; $display("FAIL wrap_count: got %0d want %0d", wr2_q.size(), FW);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    gnt_delay = 2; lat = 8;
    start_frame();
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_write);
      if (addr_q.size() >= 1) begin ok = 1; break; end
    end
    @(negedge clk_write);
    #3;
    rst_n = 0;
    #1;
    total++;
    if (ok !== 1'b1 || bus1.rd_req !== 1'b0 || bus1.rd_addr !== 24'h100 ||
        bus1.write_enable !== 1'b0 || bus1.write_data !== 16'h0 ||
        busy1 !== 1'b0 || fd1 !== 1'b0 || ov1 !== 1'b0) begin
      bad++;
      $display("FAIL rmid_outputs: got req=%b addr=%h we=%b wd=%h busy=%b want 0/100/0/0/0",
               bus1.rd_req, bus1.rd_addr, bus1.write_enable, bus1.write_data, busy1);
    end
    total++;
    if (bus2.rd_addr !== 9'h1F8 || busy2 !== 1'b0) begin
      bad++; $display("FAIL rmid_dut2: got addr=%h busy=%b want 1f8/0", bus2.rd_addr, busy2);
    end
    repeat (2) @(negedge clk_write);
    rst_n = 1;
    lat = 3;
    repeat (2) @(negedge clk_write);
    clear_logs();
    start_frame();
    wait_frame(FW, 500, ok);
    total++;
    if (ok !== 1'b1 || wr_q.size() != FW || addr_q.size() != 8) begin
      bad++; $display("FAIL rmid_frame: got words=%0d bursts=%0d want %0d/8", wr_q.size(), addr_q.size(), FW);
    end
    total++;
    if (addr_q.size() > 0 && addr_q[0] !== 24'h100) begin
      bad++; $display("FAIL rmid_first_addr: got %h want 100", addr_q[0]);
    end
    for (int i = 0; i < FW && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== mem[(32'h100 + i) & 511]) begin
        bad++; $display("FAIL rmid_word[%0d]: got %h want %h", i, wr_q[i], mem[(32'h100 + i) & 511]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    rand_gnt = 1; rand_lat = 1; rand_full = 1;
    start_frame();
    wait_frame(FW, 3000, ok);
    start_frame();
    wait_frame(2 * FW, 3000, ok);
    rand_gnt = 0; rand_lat = 0; rand_full = 0;
    total++;
    if (ok !== 1'b1 || wr_q.size() != 2 * FW) begin
      bad++; $display("FAIL b2b_count: got %0d want %0d", wr_q.size(), 2 * FW);
    end
    for (int i = 0; i < 2 * FW && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== mem[(32'h100 + (i % FW)) & 511]) begin
        bad++; $display("FAIL b2b_word[%0d]: got %h want %h", i, wr_q[i], mem[(32'h100 + (i % FW)) & 511]);
      end
    end
    total++;
    if (done_cnt != 2 || ovr_cnt != 0 || fullwe != 0 || addr_q.size() != 16) begin
      bad++; $display("FAIL b2b_status: got done=%0d ovr=%0d fullwe=%0d bursts=%0d want 2/0/0/16",
                      done_cnt, ovr_cnt, fullwe, addr_q.size());
    end
    total++;
    if (hold_viol != 0) begin
      bad++; $display("FAIL b2b_hold: got %0d want 0", hold_viol);
    end
  endtask

  initial begin
    rst_n = 0;
    fs = 0;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    clear_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_handshake();
    test_overrun();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
